// File: rtl/pipe_credit_ctrl.sv
// pipe_credit_ctrl: credit-based issue/capture controller for a fixed-latency, non-stallable datapath.
//   clk, rst_n (async, active low), flush (sync clear of in-flight and buffered work)
//   in_valid/in_ready: operand handshake; dp_en: one-cycle issue pulse to the datapath
//   dp_dout: datapath result, valid LATENCY cycles after dp_en
//   out_valid/out_data/out_ready: result FIFO head; credits: free result slots
//   PIPE_CREDIT_CTRL_STATS_EN adds stat_issued (fires) and stat_stall (in_valid & ~in_ready cycles)
module pipe_credit_ctrl #(
  parameter int WIDTH   = 16,
  parameter int LATENCY = 3,
  parameter int DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic                         dp_en,
  input  logic [WIDTH-1:0]             dp_dout,
  output logic                         out_valid,
  output logic [WIDTH-1:0]             out_data,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   credits
`ifdef PIPE_CREDIT_CTRL_STATS_EN
  ,
  output logic [31:0]                  stat_issued,
  output logic [31:0]                  stat_stall
`endif
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic             fire, pop, wr;
  logic [LATENCY-1:0] chain;
  logic [PW-1:0]    wp, rp;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] mem [DEPTH];
  assign in_ready  = credits != '0;
  assign fire      = in_valid & in_ready & ~flush;
  assign dp_en     = fire;
  assign out_valid = count != '0;
  assign pop       = out_valid & out_ready & ~flush;
  assign wr        = chain[LATENCY-1];
  assign out_data  = out_valid ? mem[rp] : '0;
  // chain[i] marks an operation issued i+1 cycles ago; the top bit lines up with a valid dp_dout.
  // A single-slot FIFO keeps its pointers at 0 (increment of zero).
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      chain   <= '0;
      wp      <= '0;
      rp      <= '0;
      count   <= '0;
      credits <= CW'(DEPTH);
    end else if (flush) begin
      chain   <= '0;
      wp      <= '0;
      rp      <= '0;
      count   <= '0;
      credits <= CW'(DEPTH);
    end else begin
      chain   <= LATENCY'({chain, fire});
      wp      <= wr ? wp + PW'(DEPTH > 1) : wp;
      rp      <= pop ? rp + PW'(DEPTH > 1) : rp;
      count   <= count + CW'(wr) - CW'(pop);
      credits <= credits - CW'(fire) + CW'(pop);
    end
  // A credit was reserved at issue, so a landing result always has a free slot.
  always_ff @(posedge clk)
    if (wr) mem[wp] <= dp_dout;
`ifdef PIPE_CREDIT_CTRL_STATS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stat_issued <= '0;
      stat_stall  <= '0;
    end else if (flush) begin
      stat_issued <= '0;
      stat_stall  <= '0;
    end else begin
      stat_issued <= stat_issued + 32'(fire);
      stat_stall  <= stat_stall + 32'(in_valid & ~in_ready);
    end
`endif
endmodule

// File: tb/tb_pipe_credit_ctrl.sv
// tb_pipe_credit_ctrl: model-checked directed bench for pipe_credit_ctrl (DEPTH 4 main, DEPTH 8 streaming)
module tb_pipe_credit_ctrl;
  localparam int LATENCY = 3;
  localparam int DEPTH   = 4;
  logic clk = 0;
  logic rst_n = 0;
  logic flush = 0, in_valid = 0, out_ready = 0;
  logic [15:0] din = 0;
  logic in_ready, dp_en, out_valid;
  logic [15:0] dp_dout, out_data;
  logic [2:0] credits;
  logic s_flush = 0, s_valid = 0, s_ordy = 1;
  logic [15:0] s_din = 0;
  logic s_ir, s_en, s_ov;
  logic [15:0] s_dout, s_od;
  logic [3:0] s_cr;
`ifdef PIPE_CREDIT_CTRL_STATS_EN
  logic [31:0] stat_issued, stat_stall, s_si, s_ss;
`endif
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  pipe_credit_ctrl #(.WIDTH(16), .LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .dp_en(dp_en), .dp_dout(dp_dout), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .credits(credits)
`ifdef PIPE_CREDIT_CTRL_STATS_EN
    , .stat_issued(stat_issued), .stat_stall(stat_stall)
`endif
  );

  pipe_credit_ctrl #(.WIDTH(16), .LATENCY(LATENCY), .DEPTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .flush(s_flush), .in_valid(s_valid), .in_ready(s_ir),
    .dp_en(s_en), .dp_dout(s_dout), .out_valid(s_ov), .out_data(s_od),
    .out_ready(s_ordy), .credits(s_cr)
`ifdef PIPE_CREDIT_CTRL_STATS_EN
    , .stat_issued(s_si), .stat_stall(s_ss)
`endif
  );

  // Bench datapath: returns the operand presented LATENCY cycles earlier.
  logic [15:0] p4 [LATENCY];
  logic [15:0] p8 [LATENCY];
  always @(posedge clk) begin
    p4[0] <= din;
    p8[0] <= s_din;
    for (int i = 1; i < LATENCY; i++) begin
      p4[i] <= p4[i-1];
      p8[i] <= p8[i-1];
    end
  end
  assign dp_dout = p4[LATENCY-1];
  assign s_dout  = p8[LATENCY-1];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  // Transaction-level model: issued ops wait LATENCY edges, then join a result queue.
  typedef struct packed { int due; logic [15:0] d; } fl_t;
  fl_t infl[$];
  fl_t ent;
  logic [15:0] mq[$];
  int mcred = DEPTH;
  int cyc = 0;
  bit mf, mp;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      infl.delete();
      mq.delete();
      mcred = DEPTH;
    end else begin
      cyc++;
      if (flush) begin
        infl.delete();
        mq.delete();
        mcred = DEPTH;
      end else begin
        mf = in_valid && mcred != 0;
        mp = mq.size() != 0 && out_ready;
        if (mp) void'(mq.pop_front());
        if (infl.size() != 0 && infl[0].due == cyc) begin
          chk("fifo_not_full_on_write", mq.size() < DEPTH, 1);
          ent = infl.pop_front();
          mq.push_back(ent.d);
        end
        if (mf) begin
          ent.due = cyc + LATENCY;
          ent.d = din;
          infl.push_back(ent);
        end
        mcred = mcred + int'(mp) - int'(mf);
      end
    end
  end

  always @(negedge clk) begin
    chk("in_ready", in_ready, mcred != 0);
    chk("credits", credits, mcred);
    chk("dp_en", dp_en, in_valid && mcred != 0 && !flush);
    chk("out_valid", out_valid, mq.size() != 0);
    if (mq.size() != 0) chk("out_data", out_data, mq[0]);
  end

  // Streaming monitor for the DEPTH 8 instance.
  int rx = 0, ncyc = 0, first = 0, last = 0;
  always @(negedge clk) begin
    ncyc++;
    if (s_ov) begin
      chk("stream_data", s_od, rx);
      if (rx == 0) first = ncyc;
      last = ncyc;
      rx++;
    end
  end

  task automatic drive(input logic iv, input logic [15:0] d, input logic ordy, input logic fl);
    @(posedge clk);
    #1;
    in_valid = iv;
    din = d;
    out_ready = ordy;
    flush = fl;
  endtask

  int nf;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_credits", credits, 4);
    chk("rst_dp_en", dp_en, 0);
    chk("rst_out_data", out_data, 0);
    @(posedge clk);
    #1 rst_n = 1;

    // single op: fire at t, result visible at t+4 only, credit back at t+5
    drive(1, 16'h1234, 1, 0); @(negedge clk); chk("single_fire", dp_en, 1);
    drive(0, 0, 1, 0); @(negedge clk); chk("single_cred_t1", credits, 3);
    drive(0, 0, 1, 0);
    drive(0, 0, 1, 0); @(negedge clk); chk("single_ov_t3", out_valid, 0);
    drive(0, 0, 1, 0); @(negedge clk);
    chk("single_ov_t4", out_valid, 1);
    chk("single_data_t4", out_data, 16'h1234);
    chk("single_cred_t4", credits, 3);
    drive(0, 0, 1, 0); @(negedge clk);
    chk("single_ov_t5", out_valid, 0);
    chk("single_cred_t5", credits, 4);

    // backpressure: exactly four fires, then full; drain in order
    nf = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1, 16'hA000 + 16'(i), 0, 0);
      @(negedge clk);
      if (dp_en) nf++;
    end
    chk("bp_fires", nf, 4);
    drive(0, 0, 0, 0); @(negedge clk);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_credits", credits, 0);
    drive(0, 0, 1, 0); @(negedge clk);
    chk("bp_pop0", out_data, 16'hA000);
    chk("bp_ready_pop_cycle", in_ready, 0);
    drive(0, 0, 1, 0); @(negedge clk);
    chk("bp_pop1", out_data, 16'hA001);
    chk("bp_ready_after_pop", in_ready, 1);
    drive(0, 0, 1, 0); @(negedge clk); chk("bp_pop2", out_data, 16'hA002);
    drive(0, 0, 1, 0); @(negedge clk); chk("bp_pop3", out_data, 16'hA003);
    drive(0, 0, 1, 0); @(negedge clk); chk("bp_empty", out_valid, 0);

    // simultaneous fire and pop at credits == 1, pointers wrapping
    for (int i = 0; i < 4; i++) drive(1, 16'hB000 + 16'(i), 0, 0);
    repeat (4) drive(0, 0, 0, 0);
    drive(0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 16'hC000 + 16'(i), 1, 0);
      @(negedge clk);
      chk("fp_credits", credits, 1);
      chk("fp_dp_en", dp_en, 1);
      chk("fp_out_valid", out_valid, 1);
    end
    repeat (8) drive(0, 0, 1, 0);

    // flush with two buffered and two in flight
    drive(1, 16'hE000, 0, 0);
    drive(1, 16'hE001, 0, 0);
    repeat (3) drive(0, 0, 0, 0);
    drive(1, 16'hE002, 0, 0);
    drive(1, 16'hE003, 0, 0);
    drive(1, 16'hE004, 1, 1); @(negedge clk);
    chk("flush_ov_during", out_valid, 1);
    drive(0, 0, 1, 0); @(negedge clk);
    chk("flush_ov_after", out_valid, 0);
    chk("flush_credits", credits, 4);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 0); @(negedge clk);
      chk("flush_no_landing", out_valid, 0);
    end
    drive(1, 16'hE005, 1, 1); @(negedge clk);
    chk("flush_blocks_fire", dp_en, 0);
    drive(0, 0, 1, 0); @(negedge clk);
    chk("flush_no_credit_use", credits, 4);

    // async reset mid-stream
    for (int i = 0; i < 5; i++) drive(1, 16'hD000 + 16'(i), 1, 0);
    @(negedge clk);
    chk("pre_rst_ov", out_valid, 1);
    chk("pre_rst_credits", credits, 0);
    #1 rst_n = 0;
    in_valid = 0;
    #1;
    chk("arst_ov", out_valid, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_credits", credits, 4);
    #13 rst_n = 1;
    drive(1, 16'h5A5A, 1, 0); @(negedge clk); chk("resume_fire", dp_en, 1);
    repeat (3) drive(0, 0, 1, 0);
    drive(0, 0, 1, 0); @(negedge clk);
    chk("resume_data", out_data, 16'h5A5A);
    chk("resume_ov", out_valid, 1);

    // statistics traffic: 10 fires, 3 stalls after a flush
    drive(0, 0, 1, 1);
    drive(0, 0, 1, 0);
`ifdef PIPE_CREDIT_CTRL_STATS_EN
    @(negedge clk);
    chk("stat_issued_flush", stat_issued, 0);
    chk("stat_stall_flush", stat_stall, 0);
`endif
    for (int i = 0; i < 7; i++) drive(1, 16'h7000 + 16'(i), 0, 0);
    repeat (8) drive(0, 0, 1, 0);
    for (int i = 0; i < 4; i++) drive(1, 16'h7100 + 16'(i), 1, 0);
    repeat (8) drive(0, 0, 1, 0);
    for (int i = 0; i < 2; i++) drive(1, 16'h7200 + 16'(i), 1, 0);
    drive(0, 0, 1, 0);
`ifdef PIPE_CREDIT_CTRL_STATS_EN
    @(negedge clk);
    chk("stat_issued", stat_issued, 10);
    chk("stat_stall", stat_stall, 3);
`endif
    repeat (6) drive(0, 0, 1, 0);

    // streaming on the DEPTH 8 instance
    nf = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      #1;
      s_valid = 1;
      s_din = 16'(k);
      @(negedge clk);
      chk("stream_in_ready", s_ir, 1);
      if (s_en) nf++;
    end
    @(posedge clk);
    #1 s_valid = 0;
    repeat (LATENCY + 4) @(negedge clk);
    chk("stream_fires", nf, 100);
    chk("stream_count", rx, 100);
    chk("stream_span", last - first, 99);
    chk("stream_credits", s_cr, 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_credit_ctrl.md
Name: pipe_credit_ctrl

Overview:
- Flow controller for a fixed-latency, non-stallable datapath pipeline, e.g. the float multiplier built from shift_reg stages.
- Accepts operands on a valid/ready interface and issues them to the datapath with a one-cycle enable pulse.
- Tracks each issued operation through a LATENCY-deep valid chain and captures each result into an internal result FIFO.
- Credits stop the block from issuing a result that the FIFO could not hold, so the datapath never needs backpressure.

Parameters:
- WIDTH, 16: datapath result width in bits.
- LATENCY, 3: datapath latency in cycles, from the dp_en cycle to the cycle dp_dout is valid. Must be >= 1.
- DEPTH, 4: result FIFO entries. Must be >= 1 and a power of two.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous reset, active low.
- flush, input, 1: synchronous clear of all in-flight and buffered operations.
- in_valid, input, 1: upstream operand valid.
- in_ready, output, 1: block can accept an operand this cycle.
- dp_en, output, 1: issue pulse to the datapath; equals in_valid & in_ready & ~flush.
- dp_dout, input, WIDTH: datapath result.
- out_valid, output, 1: FIFO head is valid.
- out_data, output, WIDTH: FIFO head data.
- out_ready, input, 1: downstream accepts the head.
- credits, output, $clog2(DEPTH+1): free slots (debug and status).

Behaviour:
- Reset (rst_n low, asynchronous):
  - valid chain cleared; FIFO pointers and count at 0; credits = DEPTH.
  - out_valid = 0, in_ready = 1, dp_en = 0; out_data reads as 0.
- Handshakes:
  - fire = in_valid & in_ready & ~flush.
  - pop = out_valid & out_ready & ~flush.
  - in_ready = (credits != 0), driven only from registered state. out_ready has no combinational path to in_ready.
  - out_valid = (fifo_count != 0).
  - in_valid may deassert without a transfer.
- Valid chain:
  - vld[0] = fire; vld[i] <= vld[i-1] for i = 1..LATENCY.
  - When vld[LATENCY] = 1, the FIFO writes dp_dout at that edge. Writes are combinational-free and cannot fail, because credits guarantee a free slot.
- Latency: operand accepted in cycle t → dp_dout sampled at the end of cycle t+LATENCY → out_valid = 1 in cycle t+LATENCY+1 when the FIFO was empty.
- Credit accounting:
  - credits_next = credits - fire + pop.
  - Simultaneous fire and pop leaves credits unchanged.
  - A pop frees its credit for the following cycle only (in_ready updates one cycle after pop).
  - Invariant: credits + in_flight + fifo_count == DEPTH at every edge.
- Throughput: with out_ready held high, one operand is accepted every cycle indefinitely, provided DEPTH >= LATENCY+2. With smaller DEPTH, in_ready duty cycle is DEPTH/(LATENCY+2).
- FIFO:
  - Circular buffer with $clog2(DEPTH)-bit pointers that wrap naturally.
  - A write and a pop in the same cycle both take effect; count is unchanged.
  - Write to a full FIFO is impossible by construction; the bench asserts this.
- Full: credits == 0 → in_ready = 0, no fire; in-flight results still land in the FIFO.
- Empty: out_valid = 0; out_data is don't-care.
- Flush (synchronous, highest priority):
  - At the edge: valid chain cleared, FIFO emptied, credits = DEPTH.
  - fire and pop are suppressed in the flush cycle. dp_en = 0 in that cycle.
  - Results already inside the datapath are discarded because their vld bits are cleared.
- Reset mid-operation: asynchronous clear to the reset state; any datapath output still in flight is ignored.

Optional Feature:
- Macro: PIPE_CREDIT_CTRL_STATS_EN.
- Defined:
  - Adds outputs stat_issued[31:0] (count of fires) and stat_stall[31:0] (cycles with in_valid & ~in_ready).
  - Both are 0 at reset and on flush, and wrap modulo 2^32.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Single op (LATENCY=3, DEPTH=4, out_ready=1): fire at cycle 2, dp_dout=16'h1234 valid in cycle 5 → out_valid=1 with out_data=16'h1234 in cycle 6 only; credits returns to 4 in cycle 7.
- Backpressure (out_ready=0, in_valid=1 held): exactly 4 fires, then in_ready=0 and credits=0. The FIFO holds 4 results in order. Release out_ready=1 → 4 pops in order; in_ready=1 again one cycle after the first pop.
- Streaming (DEPTH=8, LATENCY=3, out_ready=1): 100 consecutive operands tagged 0..99 → in_ready never drops; outputs 0..99 in order, one per cycle.
- Simultaneous fire and pop with credits=1: credits stays 1 and fifo_count is unchanged; the pointers wrap correctly past entry 3→0.
- Flush with 2 ops in flight and 2 buffered: next cycle out_valid=0 and credits=4; in-flight results emerging later produce no FIFO writes.
- Async reset asserted mid-stream for 1.5 cycles: out_valid=0, in_ready=1 and credits=4 immediately; normal operation resumes after release.
- With STATS_EN defined: 10 fires plus 3 stall cycles → stat_issued=10, stat_stall=3.
